// File: rtl/sha256_pkg.sv
// SHA-256 constants, round helper functions and engine state encoding.
package sha256_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      ST_LOAD   = 2'd0,
      ST_ROUND  = 2'd1,
      ST_UPDATE = 2'd2,
      ST_OUT    = 2'd3
   } state_e;

   localparam word_t K [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   localparam word_t IV [8] = '{
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };

   function automatic word_t rotr(input word_t x, input int unsigned n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic word_t ch(input word_t e, input word_t f, input word_t g);
      return (e & f) ^ (~e & g);
   endfunction

   function automatic word_t maj(input word_t a, input word_t b, input word_t c);
      return (a & b) ^ (a & c) ^ (b & c);
   endfunction

   function automatic word_t big_sigma0(input word_t x);
      return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
   endfunction

   function automatic word_t big_sigma1(input word_t x);
      return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
   endfunction

   function automatic word_t small_sigma0(input word_t x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic word_t small_sigma1(input word_t x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

endpackage

// File: rtl/sha256_stream_core_if.sv
// Block input stream and digest output stream of the SHA-256 engine.
interface sha256_stream_core_if #(
   parameter int unsigned DATA_W = 32
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              in_first;
   logic              in_last;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic              out_last;

   modport slave (
      input  in_valid, in_data, in_first, in_last, out_ready,
      output in_ready, out_valid, out_data, out_last
   );

   modport master (
      output in_valid, in_data, in_first, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_last
   );
endinterface

// File: rtl/sha256_msg_sched.sv
// 16-word sliding message schedule: filled by load beats, expands W[t] per round.
module sha256_msg_sched
   import sha256_pkg::*;
#(
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_load,
   input  logic              i_step,
   input  logic [DATA_W-1:0] i_data,
   output word_t             o_wt
);
   localparam int unsigned WPB = DATA_W / 32;

   word_t       r_w [16];
   logic [63:0] w_in;
   word_t       w_new;

   // Left-align the beat so the earlier word is always w_in[63:32]; compute W[t+16].
   always_comb begin
      w_in  = 64'(i_data) << (64 - DATA_W);
      w_new = small_sigma1(r_w[14]) + r_w[9] + small_sigma0(r_w[1]) + r_w[0];
   end

   // Window shift: load words enter at the top, rounds consume from the bottom.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 16; i++) r_w[i] <= '0;
      end else if (i_load) begin
         if (WPB == 1) begin
            for (int i = 0; i < 15; i++) r_w[i] <= r_w[i+1];
            r_w[15] <= w_in[63:32];
         end else begin
            for (int i = 0; i < 14; i++) r_w[i] <= r_w[i+2];
            r_w[14] <= w_in[63:32];
            r_w[15] <= w_in[31:0];
         end
      end else if (i_step) begin
         for (int i = 0; i < 15; i++) r_w[i] <= r_w[i+1];
         r_w[15] <= w_new;
      end
   end

   assign o_wt = r_w[0];
endmodule

// File: rtl/sha256_stream_core.sv
// Streaming SHA-256: block load, 64 rounds at one per cycle, chaining, digest serialiser.
module sha256_stream_core
   import sha256_pkg::*;
#(
   parameter int unsigned DATA_W = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   sha256_stream_core_if.slave  bus,
   output logic                 busy
);
   localparam int unsigned WPB    = DATA_W / 32;
   localparam int unsigned BEATS  = 16 / WPB;
   localparam int unsigned OBEATS = 8 / WPB;

   state_e            r_state, w_state_nxt;
   logic [3:0]        r_beat, w_beat_nxt;
   logic [5:0]        r_round;
   logic [2:0]        r_out_idx;
   logic              r_last;
   word_t             r_h [8];
   word_t             r_wk [8];
   word_t             w_h_sum [8];
   word_t             w_wt, w_t1, w_t2;
   logic              w_accept, w_load_done, w_out_acc, w_out_done, w_step;
   logic              r_in_ready, r_out_valid, r_out_last, r_busy;
   logic [DATA_W-1:0] r_out_data;

   function automatic logic [DATA_W-1:0] pack_out(input word_t hi, input word_t lo);
      logic [63:0] w_pair;
      w_pair = {hi, lo};
      return DATA_W'(w_pair >> (64 - DATA_W));
   endfunction

   assign w_step = (r_state == ST_ROUND);

   sha256_msg_sched #(.DATA_W(DATA_W)) u_sched (
      .clk    (clk),
      .rst    (rst),
      .i_load (w_accept),
      .i_step (w_step),
      .i_data (bus.in_data),
      .o_wt   (w_wt)
   );

   // State and beat-count register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_LOAD;
         r_beat  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_beat  <= w_beat_nxt;
      end
   end

   // Next state, beat count and handshake strobes.
   always_comb begin
      w_state_nxt = r_state;
      w_beat_nxt  = r_beat;
      w_accept    = 1'b0;
      w_load_done = 1'b0;
      w_out_acc   = 1'b0;
      w_out_done  = 1'b0;
      case (r_state)
         ST_LOAD: begin
            w_accept = r_in_ready & bus.in_valid;
            if (w_accept) begin
               if (r_beat == 4'(BEATS - 1)) begin
                  w_load_done = 1'b1;
                  w_beat_nxt  = '0;
                  w_state_nxt = ST_ROUND;
               end else begin
                  w_beat_nxt = r_beat + 4'd1;
               end
            end
         end
         ST_ROUND:  if (r_round == 6'd63) w_state_nxt = ST_UPDATE;
         ST_UPDATE: w_state_nxt = r_last ? ST_OUT : ST_LOAD;
         ST_OUT: begin
            w_out_acc = r_out_valid & bus.out_ready;
            if (w_out_acc && (r_out_idx == 3'(OBEATS - 1))) begin
               w_out_done  = 1'b1;
               w_state_nxt = ST_LOAD;
            end
         end
         default: w_state_nxt = ST_LOAD;
      endcase
   end

   // Compression round terms and the chaining sum.
   always_comb begin
      w_t1 = r_wk[7] + big_sigma1(r_wk[4]) + ch(r_wk[4], r_wk[5], r_wk[6]) + K[r_round] + w_wt;
      w_t2 = big_sigma0(r_wk[0]) + maj(r_wk[0], r_wk[1], r_wk[2]);
      for (int i = 0; i < 8; i++) w_h_sum[i] = r_h[i] + r_wk[i];
   end

   // Datapath: hash state, working registers and registered stream outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_in_ready  <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_last  <= 1'b0;
         r_busy      <= 1'b0;
         r_round     <= '0;
         r_out_idx   <= '0;
         r_last      <= 1'b0;
         for (int i = 0; i < 8; i++) begin
            r_h[i]  <= IV[i];
            r_wk[i] <= '0;
         end
      end else begin
         r_in_ready <= (w_state_nxt == ST_LOAD);
         r_busy     <= !((w_state_nxt == ST_LOAD) && (w_beat_nxt == 4'd0));
         r_round    <= w_step ? r_round + 6'd1 : 6'd0;

         // First beat of a block carries the message framing; a new message drops any chain.
         if (w_accept && (r_beat == 4'd0)) begin
            r_last <= bus.in_last;
            if (bus.in_first) begin
               for (int i = 0; i < 8; i++) r_h[i] <= IV[i];
            end
         end

         if (w_load_done) begin
            for (int i = 0; i < 8; i++) r_wk[i] <= r_h[i];
         end

         if (w_step) begin
            r_wk[0] <= w_t1 + w_t2;
            r_wk[1] <= r_wk[0];
            r_wk[2] <= r_wk[1];
            r_wk[3] <= r_wk[2];
            r_wk[4] <= r_wk[3] + w_t1;
            r_wk[5] <= r_wk[4];
            r_wk[6] <= r_wk[5];
            r_wk[7] <= r_wk[6];
         end

         if (r_state == ST_UPDATE) begin
            for (int i = 0; i < 8; i++) r_h[i] <= w_h_sum[i];
            if (r_last) begin
               r_out_valid <= 1'b1;
               r_out_data  <= pack_out(w_h_sum[0], w_h_sum[1]);
               r_out_idx   <= '0;
            end
         end

         // Digest drains by rotating H so the next words always sit at H[0..].
         if (w_out_acc) begin
            if (w_out_done) begin
               r_out_valid <= 1'b0;
               r_out_data  <= '0;
               r_out_last  <= 1'b0;
               r_out_idx   <= '0;
               for (int i = 0; i < 8; i++) r_h[i] <= IV[i];
            end else begin
               for (int i = 0; i < 8; i++) r_h[i] <= r_h[3'(i + WPB)];
               r_out_data <= pack_out(r_h[WPB], r_h[WPB+1]);
               r_out_last <= (r_out_idx == 3'(OBEATS - 2));
               r_out_idx  <= r_out_idx + 3'd1;
            end
         end
      end
   end

   assign bus.in_ready  = r_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.out_data  = r_out_data;
   assign bus.out_last  = r_out_last;
   assign busy          = r_busy;
endmodule

// File: doc/sha256_stream_core.md
# sha256_stream_core

Parametrised, streaming SHA-256 engine for the SP800-108 feedback-mode KDF datapath. It accepts pre-padded 512-bit message blocks over a valid/ready input stream and chains any number of blocks per message. It returns the 256-bit digest over a valid/ready output stream with backpressure. Bus width is configurable, and the engine runs one round per cycle.

## Interface
- `DATA_W`, default 32; input/output beat width. Legal values: 32, 64.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: input beat valid.
- `in_ready` out 1: engine accepts a beat. Reset value 0.
- `in_data` in DATA_W: message words, big-endian. With DATA_W=64, bits [63:32] hold the earlier word.
- `in_first` in 1: block starts a new message. Sampled only on beat 0 of a block.
- `in_last` in 1: block ends the message. Sampled only on beat 0 of a block.
- `out_valid` out 1: digest beat valid. Reset value 0.
- `out_ready` in 1: sink accepts a digest beat.
- `out_data` out DATA_W: digest, H0 first. With DATA_W=64, H0 sits in [63:32]. Reset value 0.
- `out_last` out 1: final digest beat. Reset value 0.
- `busy` out 1: high in any state other than LOAD with beat count 0. Reset value 0.

## Operation
- The FSM has four states: LOAD, ROUND, UPDATE, OUT. Reset enters LOAD with beat count 0 and H0..H7 set to the FIPS 180-4 IV.
- **LOAD**
  - `in_ready`=1.
  - A beat is accepted on `in_valid & in_ready`.
  - Each accepted beat fills the 16-word schedule window.
  - A block is 512/DATA_W beats: 16 for DATA_W=32, 8 for DATA_W=64.
  - On beat 0, `in_first`/`in_last` are latched.
  - If `in_first`=1, H is reloaded with the IV before the block is processed. This abandons any partially chained message.
  - After the last beat, the working registers a..h load from H and the FSM enters ROUND.
- **ROUND**
  - 64 cycles, round index t=0..63, one compression round per cycle.
  - W[t] for t<16 comes from the loaded words.
  - For t≥16, W[t] = σ1(W[t-2]) + W[t-7] + σ0(W[t-15]) + W[t-16], computed in the sliding 16-entry window.
  - All additions are mod 2^32, and carries are discarded.
- **UPDATE**
  - 1 cycle: Hi ← Hi + working register i, mod 2^32.
  - Next state is OUT if the latched `in_last`=1, otherwise LOAD, which chains the next block.
- **OUT**
  - Emits 256/DATA_W beats.
  - `out_data`/`out_last` hold stable while `out_valid & ~out_ready`.
  - After the final beat is accepted, H reloads the IV and the FSM returns to LOAD.
  - `out_valid` is 0 outside OUT, and `out_data` reads 0 outside OUT.
- `in_valid` outside LOAD is ignored, since `in_ready`=0.
- `in_first` and `in_last` may both be 1 on a single-block message.
- `rst` asserted in any state aborts the operation within that cycle. All outputs return to their reset values on the next edge, and no partial digest is emitted.

## Timing
- Last input beat of a block accepted at edge T:
  - ROUND covers T+1..T+64.
  - UPDATE at T+65.
  - At T+66, either `out_valid`=1 (last block) or `in_ready`=1 (chained block).
- Per-block throughput: 512/DATA_W + 65 cycles, excluding stalls.
- Digest drain: 8 (DATA_W=32) or 4 (DATA_W=64) cycles with `out_ready` held high.
- `in_ready` first rises on the first edge after `rst` deasserts.
- A new message may start the cycle after the final digest beat is accepted.

## Structure
- `sha256_pkg` holds:
  - the K[0:63] constant table and the IV[0:7] constants;
  - the functions Ch, Maj, Σ0, Σ1, σ0, σ1;
  - the FSM state enum.
- Sub-module `sha256_msg_sched`: the 16×32 sliding window. It shifts in load words (1 or 2 per beat) during LOAD and produces W[t] during ROUND.
- The top contains the FSM, beat/round counters, working registers, H registers and the output serialiser.

## Test plan
- **"abc" single block**, DATA_W=32.
  - Stimulus: 61626380, 14× 00000000, 00000018; `in_first`=`in_last`=1.
  - Required: ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
  - `out_valid` at T+66; `out_last` on beat 8.
- **Empty message**, DATA_W=64.
  - Stimulus: 8000000000000000, then 7× 0.
  - Required: e3b0c44298fc1c14 9afbf4c8996fb924 27ae41e4649b934c a495991b7852b855, in 4 beats.
- **Two-block chaining**: the 56-byte "abcdbcdecdefdefg…nopq" test vector.
  - Required digest: 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
  - `in_ready`=0 for exactly 65 cycles between the blocks.
- **Backpressure**: random `out_ready` and random `in_valid` gaps on the "abc" vector.
  - Required: same digest, and `out_data` stable across stalls.
- **Restart**: block 1 of the two-block message, then "abc" with `in_first`=1.
  - Required: the "abc" digest.
- **Reset mid-ROUND** at round 30, then "abc".
  - Required: all outputs return to reset values on the next edge, and the correct "abc" digest follows.
